// File: rtl/ps2_cmd_pkg.sv
// Shared byte codes, error codes and FSM encoding for the PS/2 command sequencer.
package ps2_cmd_pkg;

  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] RESEND    = 8'hFE;
  localparam logic [7:0] RESET_CMD = 8'hFF;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] BAT_FAIL  = 8'hFC;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RETRY   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_BAT     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR,
    ST_INIT,
    ST_BAT_WAIT
  } state_e;

  // Which byte the single SEND state puts on the wire.
  typedef enum logic [1:0] {
    SEL_CMD,
    SEL_ARG,
    SEL_RST
  } sel_e;

endpackage

// File: rtl/ps2_cmd_timer.sv
// Loadable down-counter; expired is high during the last enabled cycle of a wait window.
module ps2_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(TIMEOUT_CYCLES);
    end else if (enable && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Window of exactly TIMEOUT_CYCLES cycles counted from the loading edge.
  assign expired = enable && (cnt_q == W'(1));

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 command sequencer: strobes bytes to the transceiver, handles ACK/RESEND/timeout, forwards scan codes.
// Define PS2_CMD_BAT_EN to send a device reset (0xFF) and check BAT after reset.
module ps2_cmd_ctrl
  import ps2_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       done_tick,
  output logic       err_tick,
  output logic [1:0] err_code,
  output logic       w_enable,
  output logic [7:0] ps2_din,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       scan_valid,
  output logic [7:0] scan_code
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

`ifdef PS2_CMD_BAT_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e          state_q, state_d;
  sel_e            sel_q, sel_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      cmd_q, cmd_d, arg_q, arg_d;
  logic            has_arg_q, has_arg_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            ready_q;
  logic            scan_valid_q;
  logic [7:0]      scan_code_q;
  logic            fwd;
  logic            is_ack, is_resend;
  logic            tmr_load, tmr_en, tmr_expired;
  logic [1:0]      tmo_code, retry_code;

  assign is_ack    = rx_done_tick && (rx_data == ACK);
  assign is_resend = rx_done_tick && (rx_data == RESEND);
  assign tmo_code   = (sel_q == SEL_RST) ? ERR_BAT : ERR_TIMEOUT;
  assign retry_code = (sel_q == SEL_RST) ? ERR_BAT : ERR_RETRY;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    retry_d    = retry_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    err_code_d = err_code_q;
    fwd        = rx_done_tick;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          cmd_d     = cmd_byte;
          arg_d     = cmd_arg;
          has_arg_d = cmd_has_arg;
          sel_d     = SEL_CMD;
          retry_d   = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_done_tick) begin
          state_d = ST_WAIT_ACK;
        end else if (tmr_expired) begin
          err_code_d = tmo_code;
          state_d    = ST_ERR;
        end
      end
      ST_WAIT_ACK: begin
        // A response arriving in the expiry cycle takes priority over the timeout.
        if (is_ack) begin
          fwd = 1'b0;
          if (sel_q == SEL_CMD && has_arg_q) begin
            sel_d   = SEL_ARG;
            retry_d = '0;
            state_d = ST_SEND;
          end else if (sel_q == SEL_RST) begin
            state_d = ST_BAT_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end else if (is_resend) begin
          fwd = 1'b0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_SEND;
          end else begin
            err_code_d = retry_code;
            state_d    = ST_ERR;
          end
        end else if (tmr_expired) begin
          err_code_d = tmo_code;
          state_d    = ST_ERR;
        end
      end
`ifdef PS2_CMD_BAT_EN
      ST_INIT: begin
        sel_d   = SEL_RST;
        retry_d = '0;
        state_d = ST_SEND;
      end
      ST_BAT_WAIT: begin
        if (rx_done_tick && rx_data == BAT_OK) begin
          fwd     = 1'b0;
          state_d = ST_DONE;
        end else if ((rx_done_tick && rx_data == BAT_FAIL) || tmr_expired) begin
          fwd        = 1'b0;
          err_code_d = ERR_BAT;
          state_d    = ST_ERR;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmr_en   = (state_q inside {ST_WAIT_TX, ST_WAIT_ACK, ST_BAT_WAIT});
  assign tmr_load = (state_d != state_q) && (state_d inside {ST_WAIT_TX, ST_WAIT_ACK, ST_BAT_WAIT});

  ps2_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      sel_q        <= SEL_CMD;
      retry_q      <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
      ready_q      <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      retry_q      <= retry_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      err_code_q   <= err_code_d;
      ready_q      <= (state_d == ST_IDLE);
      scan_valid_q <= rx_done_tick && fwd;
      if (rx_done_tick && fwd) begin
        scan_code_q <= rx_data;
      end
    end
  end

  always_comb begin
    ps2_din = 8'h00;
    if (state_q == ST_SEND) begin
      case (sel_q)
        SEL_ARG: ps2_din = arg_q;
        SEL_RST: ps2_din = RESET_CMD;
        default: ps2_din = cmd_q;
      endcase
    end
  end

  assign cmd_ready  = ready_q;
  assign w_enable   = (state_q == ST_SEND);
  assign done_tick  = (state_q == ST_DONE);
  assign err_tick   = (state_q == ST_ERR);
  assign err_code   = err_code_q;
  assign scan_valid = scan_valid_q;
  assign scan_code  = scan_code_q;

endmodule
